dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters: the pipeline MEM stage (core) and the debug/loader port (dbg).
- Sits between both requesters and data_memory, and drives that block's wr_en, mem_ctrl, addr and data_in.
- Arbitration is round-robin per access, with a debug bus-lock and a core anti-starvation limit.
- Returns registered read data with a 1-cycle response.

---
 rtl/dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core MEM stage and the debug port.
// Round-robin per access, with a debug bus-lock and a core anti-starvation limit.
// Optional address bounds checking is compiled in when DMEM_ARB_BOUNDS_EN is defined.

package control_types_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef struct packed {
        logic        we;
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

module dmem_arbiter
    import control_types_pkg::*;
#(
    parameter int unsigned MEM_SIZE_BYTES = 1024,
    parameter int unsigned MAX_STALL      = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req,
    input  logic        core_we,
    input  mem_op_t     core_op,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  mem_op_t     dbg_op,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    input  logic        dbg_lock,

    output logic        mem_wr_en,
    output mem_op_t     mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_dbg;
    logic [CNT_W-1:0] stall_cnt;
    logic             starve;
    logic             grant_core;
    logic             grant_dbg;
    logic             core_oob;
    logic             dbg_oob;
    logic             win_oob;
    logic             core_ld;
    logic             dbg_ld;
    mem_req_t         core_bus;
    mem_req_t         dbg_bus;
    mem_req_t         win_bus;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    assign core_bus = '{we: core_we, op: core_op, addr: core_addr, wdata: core_wdata};
    assign dbg_bus  = '{we: dbg_we,  op: dbg_op,  addr: dbg_addr,  wdata: dbg_wdata};

`ifdef DMEM_ARB_BOUNDS_EN
    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    // NOP never touches memory, so it can never be out of range.
    function automatic logic out_of_range(input mem_op_t op, input logic [31:0] addr);
        return (op != MEM_NOP) &&
               (({1'b0, addr} + 33'(op_size(op))) > 33'(MEM_SIZE_BYTES));
    endfunction

    assign core_oob = out_of_range(core_op, core_addr);
    assign dbg_oob  = out_of_range(dbg_op, dbg_addr);
`else
    assign core_oob = 1'b0;
    assign dbg_oob  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_OPEN;
            ST_OPEN:   if (grant_dbg && dbg_lock) state_nxt = ST_LOCKED;
            ST_LOCKED: if (!dbg_lock) state_nxt = ST_OPEN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Grant selection; starvation override beats both the lock and round-robin.
    always_comb begin
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        starve     = (stall_cnt == CNT_W'(MAX_STALL)) && core_req;
        case (state)
            ST_OPEN: begin
                if (starve) begin
                    grant_core = 1'b1;
                end else if (core_req && dbg_req) begin
                    grant_core = last_dbg;
                    grant_dbg  = !last_dbg;
                end else begin
                    grant_core = core_req;
                    grant_dbg  = dbg_req;
                end
            end
            ST_LOCKED: begin
                if (starve) begin
                    grant_core = 1'b1;
                end else begin
                    grant_dbg = dbg_req;
                end
            end
            default: ;
        endcase
    end

    assign core_gnt = grant_core;
    assign dbg_gnt  = grant_dbg;
    assign win_bus  = grant_dbg ? dbg_bus : core_bus;
    assign win_oob  = grant_dbg ? dbg_oob : core_oob;
    assign core_ld  = grant_core && !core_we && is_load(core_op);
    assign dbg_ld   = grant_dbg && !dbg_we && is_load(dbg_op);

    // Memory-side steering; out-of-range accesses are granted but squashed.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_ctrl  = MEM_NOP;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_core || grant_dbg) begin
            mem_addr  = win_bus.addr;
            mem_wdata = win_bus.wdata;
            if (!win_oob) begin
                mem_wr_en = win_bus.we;
                mem_ctrl  = win_bus.op;
            end
        end
    end

    // Round-robin history and core starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_dbg  <= 1'b1;
            stall_cnt <= '0;
        end else begin
            if (grant_core) begin
                last_dbg <= 1'b0;
            end else if (grant_dbg) begin
                last_dbg <= 1'b1;
            end
            if (!core_req || grant_core) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_W'(MAX_STALL)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Registered load responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= '0;
        end else begin
            core_rvalid <= core_ld;
            dbg_rvalid  <= dbg_ld;
            if (core_ld) begin
                core_rdata <= core_oob ? DW'(0) : mem_rdata;
            end
            if (dbg_ld) begin
                dbg_rdata <= dbg_oob ? DW'(0) : mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_BOUNDS_EN
    logic core_err_q;
    logic dbg_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_err_q <= 1'b0;
            dbg_err_q  <= 1'b0;
        end else begin
            core_err_q <= grant_core && core_oob;
            dbg_err_q  <= grant_dbg && dbg_oob;
        end
    end

    assign core_err = core_err_q;
    assign dbg_err  = dbg_err_q;
`else
    assign core_err = 1'b0;
    assign dbg_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small byte-addressed memory model.
// Bounds-check expectations follow DMEM_ARB_BOUNDS_EN.

module tb_dmem_arbiter;
    import control_types_pkg::*;

    localparam int NV = 11;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
    mem_op_t     core_op, dbg_op;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_wr_en;
    mem_op_t     mem_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_op(dbg_op),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .dbg_lock(dbg_lock),
        .mem_wr_en(mem_wr_en), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Little-endian byte memory with the load extension data_memory performs.
    bit   [7:0] mem [1024];
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        b0 = mem[10'(mem_addr)];
        b1 = mem[10'(mem_addr + 32'd1)];
        b2 = mem[10'(mem_addr + 32'd2)];
        b3 = mem[10'(mem_addr + 32'd3)];
        case (mem_ctrl)
            MEM_LB:  mem_rdata = {{24{b0[7]}}, b0};
            MEM_LBU: mem_rdata = {24'd0, b0};
            MEM_LH:  mem_rdata = {{16{b1[7]}}, b1, b0};
            MEM_LHU: mem_rdata = {16'd0, b1, b0};
            MEM_LW:  mem_rdata = {b3, b2, b1, b0};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            case (mem_ctrl)
                MEM_SB: mem[10'(mem_addr)] <= mem_wdata[7:0];
                MEM_SH: begin
                    mem[10'(mem_addr)]         <= mem_wdata[7:0];
                    mem[10'(mem_addr + 32'd1)] <= mem_wdata[15:8];
                end
                MEM_SW: begin
                    mem[10'(mem_addr)]         <= mem_wdata[7:0];
                    mem[10'(mem_addr + 32'd1)] <= mem_wdata[15:8];
                    mem[10'(mem_addr + 32'd2)] <= mem_wdata[23:16];
                    mem[10'(mem_addr + 32'd3)] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        cr;  logic cw;  mem_op_t cop; logic [31:0] ca; logic [31:0] cd;
        logic        dr;  logic dw;  mem_op_t dop; logic [31:0] da; logic [31:0] dd;
        logic        lk;
        logic        e_cg; logic e_dg; logic e_we; mem_op_t e_ctrl;
        logic [31:0] e_addr; logic [31:0] e_wd;
        logic        e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd;
    } vec_t;

    vec_t vt [NV];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic cr, input logic cw, input mem_op_t cop, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw, input mem_op_t dop,
                       input logic [31:0] da, input logic [31:0] dd, input logic lk);
        core_req = cr; core_we = cw; core_op = cop; core_addr = ca; core_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_op = dop; dbg_addr = da; dbg_wdata = dd;
        dbg_lock = lk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string nm, input logic cg, input logic dg);
        chk1({nm, " core_gnt"}, core_gnt, cg);
        chk1({nm, " dbg_gnt"}, dbg_gnt, dg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // v0-v9: round-robin, store/load ordering, extension, back-to-back; v10 sets up the lock
        vt[0]  = '{H,H,MEM_SW, 32'h200,32'h000080F0, H,H,MEM_SW, 32'h100,32'hA5A5A5A5, L,
                   H,L,H,MEM_SW, 32'h200,32'h000080F0, L,32'h0, L,32'h0};
        vt[1]  = '{H,L,MEM_LW, 32'h100,32'h0, H,H,MEM_SW, 32'h100,32'hA5A5A5A5, L,
                   L,H,H,MEM_SW, 32'h100,32'hA5A5A5A5, L,32'h0, L,32'h0};
        vt[2]  = '{H,L,MEM_LW, 32'h100,32'h0, H,L,MEM_LW, 32'h200,32'h0, L,
                   H,L,L,MEM_LW, 32'h100,32'h0, L,32'h0, L,32'h0};
        vt[3]  = '{H,L,MEM_LB, 32'h200,32'h0, H,L,MEM_LW, 32'h200,32'h0, L,
                   L,H,L,MEM_LW, 32'h200,32'h0, H,32'hA5A5A5A5, L,32'h0};
        vt[4]  = '{H,L,MEM_LB, 32'h200,32'h0, L,L,MEM_NOP,32'h0,32'h0, L,
                   H,L,L,MEM_LB, 32'h200,32'h0, L,32'hA5A5A5A5, H,32'h000080F0};
        vt[5]  = '{H,L,MEM_LHU,32'h200,32'h0, L,L,MEM_NOP,32'h0,32'h0, L,
                   H,L,L,MEM_LHU,32'h200,32'h0, H,32'hFFFFFFF0, L,32'h000080F0};
        vt[6]  = '{H,H,MEM_SB, 32'h300,32'h12, L,L,MEM_NOP,32'h0,32'h0, L,
                   H,L,H,MEM_SB, 32'h300,32'h12, H,32'h000080F0, L,32'h000080F0};
        vt[7]  = '{L,L,MEM_NOP,32'h0,32'h0, L,L,MEM_NOP,32'h0,32'h0, L,
                   L,L,L,MEM_NOP,32'h0,32'h0, L,32'h000080F0, L,32'h000080F0};
        vt[8]  = '{L,L,MEM_NOP,32'h0,32'h0, H,L,MEM_LBU,32'h300,32'h0, L,
                   L,H,L,MEM_LBU,32'h300,32'h0, L,32'h000080F0, L,32'h000080F0};
        vt[9]  = '{L,L,MEM_NOP,32'h0,32'h0, L,L,MEM_NOP,32'h0,32'h0, L,
                   L,L,L,MEM_NOP,32'h0,32'h0, L,32'h000080F0, H,32'h00000012};
        vt[10] = '{H,L,MEM_LW, 32'h104,32'h0, H,H,MEM_SW, 32'h104,32'hD0000000, H,
                   H,L,L,MEM_LW, 32'h104,32'h0, L,32'h000080F0, L,32'h00000012};

        // Reset held with both requesters active
        rst_n = 1'b0;
        drv(H, L, MEM_LW, 32'h100, 32'h0, H, H, MEM_SW, 32'h100, 32'h1, L);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_gnt($sformatf("rst%0d", i), L, L);
            chk1($sformatf("rst%0d mem_wr_en", i), mem_wr_en, L);
            chk1($sformatf("rst%0d core_rvalid", i), core_rvalid, L);
            chk1($sformatf("rst%0d dbg_rvalid", i), dbg_rvalid, L);
            chk32($sformatf("rst%0d core_rdata", i), core_rdata, 32'h0);
            chk32($sformatf("rst%0d dbg_rdata", i), dbg_rdata, 32'h0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drv(vt[i].cr, vt[i].cw, vt[i].cop, vt[i].ca, vt[i].cd,
                vt[i].dr, vt[i].dw, vt[i].dop, vt[i].da, vt[i].dd, vt[i].lk);
            @(negedge clk);
            chk_gnt($sformatf("v%0d", i), vt[i].e_cg, vt[i].e_dg);
            chk1($sformatf("v%0d mem_wr_en", i), mem_wr_en, vt[i].e_we);
            chk32($sformatf("v%0d mem_ctrl", i), 32'(mem_ctrl), 32'(vt[i].e_ctrl));
            chk32($sformatf("v%0d mem_addr", i), mem_addr, vt[i].e_addr);
            chk32($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].e_wd);
            chk1($sformatf("v%0d core_rvalid", i), core_rvalid, vt[i].e_crv);
            chk32($sformatf("v%0d core_rdata", i), core_rdata, vt[i].e_crd);
            chk1($sformatf("v%0d dbg_rvalid", i), dbg_rvalid, vt[i].e_drv);
            chk32($sformatf("v%0d dbg_rdata", i), dbg_rdata, vt[i].e_drd);
            tick();
        end

        // Lock with core starving: 8 dbg grants, forced core grant, dbg again while locked
        for (int i = 1; i <= 10; i++) begin
            drv(H, L, MEM_LW, 32'h104, 32'h0, H, H, MEM_SW, 32'h104, 32'hD0000000 + 32'(i), H);
            @(negedge clk);
            chk_gnt($sformatf("lock%0d", i), (i == 9), (i != 9));
            if (i == 1) begin
                chk1("lock1 core_rvalid", core_rvalid, H);
                chk32("lock1 core_rdata", core_rdata, 32'h0);
            end
            if (i == 9) begin
                chk32("lock9 mem_ctrl", 32'(mem_ctrl), 32'(MEM_LW));
                chk1("lock9 mem_wr_en", mem_wr_en, L);
            end
            if (i == 10) begin
                chk1("lock10 core_rvalid", core_rvalid, H);
                chk32("lock10 core_rdata", core_rdata, 32'hD0000008);
            end
            tick();
        end

        // Locked with dbg idle: nobody is granted
        drv(H, L, MEM_LW, 32'h104, 32'h0, L, L, MEM_NOP, 32'h0, 32'h0, H);
        @(negedge clk);
        chk_gnt("lock11", L, L);
        chk1("lock11 mem_wr_en", mem_wr_en, L);
        tick();

        // Release: still locked this cycle, then round-robin starting with core
        drv(H, L, MEM_LW, 32'h104, 32'h0, H, H, MEM_SW, 32'h104, 32'hD000000C, L);
        @(negedge clk);
        chk_gnt("rel12", L, H);
        tick();
        @(negedge clk);
        chk_gnt("rel13", H, L);
        tick();
        drv(H, L, MEM_LW, 32'h108, 32'h0, H, H, MEM_SW, 32'h104, 32'hD000000C, L);
        @(negedge clk);
        chk_gnt("rel14", L, H);
        chk1("rel14 core_rvalid", core_rvalid, H);
        chk32("rel14 core_rdata", core_rdata, 32'hD000000C);
        tick();

        // Reset in the middle of a locked dbg load
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, H, MEM_SW, 32'h108, 32'h11, H);
        @(negedge clk);
        chk_gnt("mrst1", L, H);
        tick();
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, L, MEM_LW, 32'h100, 32'h0, H);
        rst_n = 1'b0;
        @(negedge clk);
        chk_gnt("mrst2", L, H);
        tick();
        rst_n = 1'b1;
        drv(H, L, MEM_LW, 32'h100, 32'h0, H, L, MEM_LW, 32'h100, 32'h0, H);
        @(negedge clk);
        chk_gnt("mrst3", L, L);
        chk1("mrst3 dbg_rvalid", dbg_rvalid, L);
        chk32("mrst3 dbg_rdata", dbg_rdata, 32'h0);
        chk32("mrst3 core_rdata", core_rdata, 32'h0);
        tick();
        @(negedge clk);
        chk_gnt("mrst4", H, L);
        tick();

        // Top-of-memory accesses
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, H, MEM_SW, 32'h3FE, 32'hFFFFFFFF, L);
        @(negedge clk);
        chk_gnt("bnd1", L, H);
`ifdef DMEM_ARB_BOUNDS_EN
        chk1("bnd1 mem_wr_en", mem_wr_en, L);
        chk32("bnd1 mem_ctrl", 32'(mem_ctrl), 32'(MEM_NOP));
`else
        chk1("bnd1 mem_wr_en", mem_wr_en, H);
        chk32("bnd1 mem_ctrl", 32'(mem_ctrl), 32'(MEM_SW));
`endif
        chk1("bnd1 dbg_err", dbg_err, L);
        tick();
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, H, MEM_SB, 32'h3FF, 32'h5A, L);
        @(negedge clk);
        chk_gnt("bnd2", L, H);
        chk1("bnd2 mem_wr_en", mem_wr_en, H);
`ifdef DMEM_ARB_BOUNDS_EN
        chk1("bnd2 dbg_err", dbg_err, H);
`else
        chk1("bnd2 dbg_err", dbg_err, L);
`endif
        chk1("bnd2 dbg_rvalid", dbg_rvalid, L);
        tick();
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, L, MEM_LBU, 32'h3FF, 32'h0, L);
        @(negedge clk);
        chk1("bnd3 dbg_err", dbg_err, L);
        tick();
        drv(L, L, MEM_NOP, 32'h0, 32'h0, H, L, MEM_LW, 32'h3FD, 32'h0, L);
        @(negedge clk);
        chk_gnt("bnd4", L, H);
`ifdef DMEM_ARB_BOUNDS_EN
        chk32("bnd4 mem_ctrl", 32'(mem_ctrl), 32'(MEM_NOP));
`else
        chk32("bnd4 mem_ctrl", 32'(mem_ctrl), 32'(MEM_LW));
`endif
        chk1("bnd4 dbg_rvalid", dbg_rvalid, H);
        chk32("bnd4 dbg_rdata", dbg_rdata, 32'h0000005A);
        chk1("bnd4 dbg_err", dbg_err, L);
        tick();
        drv(L, L, MEM_NOP, 32'h0, 32'h0, L, L, MEM_NOP, 32'h0, 32'h0, L);
        @(negedge clk);
        chk1("bnd5 dbg_rvalid", dbg_rvalid, H);
`ifdef DMEM_ARB_BOUNDS_EN
        chk1("bnd5 dbg_err", dbg_err, H);
        chk32("bnd5 dbg_rdata", dbg_rdata, 32'h0);
`else
        chk1("bnd5 dbg_err", dbg_err, L);
        chk32("bnd5 dbg_rdata", dbg_rdata, 32'hFF5AFF00);
`endif
        chk1("bnd5 core_err", core_err, L);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
